// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the program counter, fetches one RV32I word per
// request/ack handshake and presents it to the decoder until it is consumed.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] prog,
    output logic [31:0] pc,
    output logic        prog_valid,
    input  logic        stall,
    input  logic        jmpe,
    input  logic [31:0] jmp_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_imem_addr;
    logic [31:0] r_prog;
    logic [31:0] r_pc;
    logic        r_prog_valid;
    logic        w_fetch_done;
    logic        w_consume;
    logic [31:0] w_next_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_fetch_done = 1'b0;
        w_consume    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_fetch_done = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_prog_valid && !stall) begin
                    w_consume    = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A redirect only counts on the consume edge; the low address bits are dropped.
    assign w_next_addr = jmpe ? {jmp_addr[31:2], 2'b00} : r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_addr  <= RESET_PC;
            r_prog       <= NOP_WORD;
            r_pc         <= RESET_PC;
            r_prog_valid <= 1'b0;
        end else begin
            if (w_fetch_done) begin
                r_prog       <= imem_rdata;
                r_pc         <= r_imem_addr;
                r_prog_valid <= 1'b1;
            end
            if (w_consume) begin
                r_prog_valid <= 1'b0;
                r_imem_addr  <= w_next_addr;
            end
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_imem_addr;
    assign prog       = r_prog;
    assign pc         = r_pc;
    assign prog_valid = r_prog_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a table of fetch vectors driven through a
// memory responder model, with a scoreboard queue of expected fetch addresses.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] prog;
    logic [31:0] pc;
    logic        prog_valid;
    logic        stall;
    logic        jmpe;
    logic [31:0] jmp_addr;

    int checks   = 0;
    int failures = 0;

    int          ack_delay = 0;
    logic [31:0] exp_fetch = 32'h0;
    logic        stray_ack = 1'b1;
    logic [31:0] exp_q[$];

    typedef struct {
        int          ack_delay;
        int          stall_cyc;
        bit          mid_jmp;
        bit          jmpe;
        logic [31:0] jmp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[9];

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .prog       (prog),
        .pc         (pc),
        .prog_valid (prog_valid),
        .stall      (stall),
        .jmpe       (jmpe),
        .jmp_addr   (jmp_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'h0A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay wait cycles, garbage data without ack.
    initial begin
        bit mem_busy;
        int mem_wait;
        int mem_delay;
        logic [31:0] mem_addr;
        mem_busy   = 1'b0;
        mem_wait   = 0;
        mem_delay  = 0;
        mem_addr   = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy  = 1'b1;
                    mem_wait  = 0;
                    mem_delay = ack_delay;
                    mem_addr  = imem_addr;
                    check("fetch_addr", imem_addr, exp_fetch);
                end else begin
                    check("addr_stable", imem_addr, mem_addr);
                end
                imem_ack   = (mem_wait >= mem_delay);
                imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;
                mem_wait++;
            end else begin
                mem_busy   = 1'b0;
                imem_ack   = stray_ack;
                imem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Waits for prog_valid after a request starts; checks latency, retention and output.
    task automatic wait_fetch(input int delay, input logic [31:0] tbl_pc, input logic [31:0] held_prog);
        int n;
        logic [31:0] sb_pc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            jmpe = 1'b0;
            if (n == 1) check("req_rise", 32'(imem_req), 32'h1);
            if (!prog_valid) check("prog_retained", prog, held_prog);
        end while (!prog_valid && n < 50);
        check("latency", 32'(n), 32'(delay + 2));
        check("req_drop", 32'(imem_req), 32'h0);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
        end else begin
            sb_pc = exp_q.pop_front();
            check("sb_pc", pc, sb_pc);
        end
        check("tbl_pc", pc, tbl_pc);
        check("prog", prog, mem_word(tbl_pc));
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] next;
        logic [31:0] held;
        tbl[0] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[1] = '{0, 5, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004};
        tbl[2] = '{3, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008};
        tbl[3] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C};
        tbl[4] = '{1, 0, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_0010};
        tbl[5] = '{0, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0100};
        tbl[6] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC};
        tbl[7] = '{2, 1, 1'b0, 1'b1, 32'h0000_0041, 32'h0000_0000};
        tbl[8] = '{0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0040};

        rst      = 1'b1;
        stall    = 1'b0;
        jmpe     = 1'b0;
        jmp_addr = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_prog", prog, NOP);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(prog_valid), 32'h0);

        rst       = 1'b0;
        stray_ack = 1'b0;
        ack_delay = tbl[0].ack_delay;
        exp_fetch = 32'h0;
        exp_q.push_back(32'h0);
        held = NOP;

        for (int i = 0; i < 9; i++) begin
            wait_fetch(tbl[i].ack_delay, tbl[i].exp_pc, held);
            cur  = tbl[i].exp_pc;
            held = mem_word(cur);
            for (int s = 0; s < tbl[i].stall_cyc; s++) begin
                stall     = 1'b1;
                stray_ack = 1'b1;
                jmpe      = tbl[i].mid_jmp && (s == tbl[i].stall_cyc / 2);
                jmp_addr  = 32'h0000_0200;
                @(negedge clk);
                check("stall_valid", 32'(prog_valid), 32'h1);
                check("stall_pc", pc, cur);
                check("stall_prog", prog, held);
                check("stall_req", 32'(imem_req), 32'h0);
            end
            stall     = 1'b0;
            stray_ack = 1'b0;
            jmpe      = tbl[i].jmpe;
            jmp_addr  = tbl[i].jmp_addr;
            next      = tbl[i].jmpe ? {tbl[i].jmp_addr[31:2], 2'b00} : cur + 32'd4;
            exp_q.push_back(next);
            exp_fetch = next;
            ack_delay = (i + 1 < 9) ? tbl[i + 1].ack_delay : 4;
        end

        // Reset while a request is pending in S_REQ, then refetch RESET_PC.
        @(negedge clk);
        jmpe = 1'b0;
        check("pend_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        check("pend_valid", 32'(prog_valid), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_req", 32'(imem_req), 32'h0);
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_prog", prog, NOP);
        check("rst2_pc", pc, 32'h0);
        check("rst2_valid", 32'(prog_valid), 32'h0);
        rst       = 1'b0;
        ack_delay = 0;
        exp_fetch = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        wait_fetch(0, 32'h0, NOP);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
